// File: rtl/mem_axi_wr_2x1_arb_pkg.sv
// Shared definitions for the two-master AXI write arbiter.
// Holds the FSM state encoding, the AXI IDs stamped on each master's
// transactions, and the constant values driven on the unused AW attributes.
package mem_axi_wr_2x1_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAw,
    StW,
    StB
  } state_e;

  // AXI ID identifying the originating master on the memory port.
  localparam int unsigned M0_ID = 0;  // dcache writeback
  localparam int unsigned M1_ID = 1;  // uncached store

  // Normal access, non-cacheable, unprivileged secure data.
  localparam logic       AXI_LOCK  = 1'b0;
  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT  = 3'b000;

endpackage

// File: rtl/mem_axi_wr_2x1_arb_rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   req[1:0]    request per master
//   last_grant  master that completed most recently (0 or 1)
//   grant[1:0]  one-hot grant; zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie, favour the master that did not complete last.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_axi_wr_2x1_arb.sv
// Arbitrates two AXI write masters onto one memory write port, one transaction
// at a time. The memory-side WLAST is generated from a beat counter against the
// accepted AWLEN; a disagreeing master WLAST raises the sticky wlast_err flag.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   m0_* / m1_*            AW/W/B of master 0 (dcache wb) and master 1 (uncached)
//   s_axi_*                AW/W/B toward memory (awid = originating master)
//   wlast_err              sticky master-WLAST mismatch flag
module mem_axi_wr_2x1_arb
  import mem_axi_wr_2x1_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] m0_awaddr,
  input  logic [7:0]            m0_awlen,
  input  logic [2:0]            m0_awsize,
  input  logic [1:0]            m0_awburst,
  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [STRB_WIDTH-1:0] m0_wstrb,
  input  logic                  m0_wlast,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic                  m0_bvalid,
  output logic [1:0]            m0_bresp,
  input  logic                  m0_bready,
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  input  logic [7:0]            m1_awlen,
  input  logic [2:0]            m1_awsize,
  input  logic [1:0]            m1_awburst,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [STRB_WIDTH-1:0] m1_wstrb,
  input  logic                  m1_wlast,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  output logic [1:0]            m1_bresp,
  input  logic                  m1_bready,
  output logic [ID_WIDTH-1:0]   s_axi_awid,
  output logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  output logic [7:0]            s_axi_awlen,
  output logic [2:0]            s_axi_awsize,
  output logic [1:0]            s_axi_awburst,
  output logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  output logic                  s_axi_awlock,
  output logic [3:0]            s_axi_awcache,
  output logic [2:0]            s_axi_awprot,
  output logic [DATA_WIDTH-1:0] s_axi_wdata,
  output logic [STRB_WIDTH-1:0] s_axi_wstrb,
  output logic                  s_axi_wlast,
  output logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic [ID_WIDTH-1:0]   s_axi_bid,
  input  logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_bvalid,
  output logic                  s_axi_bready,
  output logic                  wlast_err
);

  state_e                state_q, state_d;
  logic                  sel_q, sel_d;    // granted master
  logic                  last_q, last_d;  // master that completed last
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [1:0]            awburst_q, awburst_d;

  logic [1:0] grant;
  logic       in_idle, in_w, in_b;
  logic       mst_wvalid, mst_wlast;

  // Response ID is not checked: only one transaction is ever outstanding.
  logic unused_bid;
  assign unused_bid = ^s_axi_bid;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_awvalid, m0_awvalid}),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign s_axi_awid    = awid_q;
  assign s_axi_awaddr  = awaddr_q;
  assign s_axi_awlen   = awlen_q;
  assign s_axi_awsize  = awsize_q;
  assign s_axi_awburst = awburst_q;
  assign s_axi_awlock  = AXI_LOCK;
  assign s_axi_awcache = AXI_CACHE;
  assign s_axi_awprot  = AXI_PROT;
  assign wlast_err     = err_q;

  always_comb begin
    // Every handshake output is gated by resetn so nothing fires during reset.
    in_idle = resetn && (state_q == StIdle);
    in_w    = resetn && (state_q == StW);
    in_b    = resetn && (state_q == StB);

    mst_wvalid   = sel_q ? m1_wvalid : m0_wvalid;
    mst_wlast    = sel_q ? m1_wlast : m0_wlast;
    s_axi_wdata  = sel_q ? m1_wdata : m0_wdata;
    s_axi_wstrb  = sel_q ? m1_wstrb : m0_wstrb;
    s_axi_wlast  = (cnt_q == awlen_q);
    s_axi_wvalid = in_w && mst_wvalid;
    m0_wready    = in_w && !sel_q && s_axi_wready;
    m1_wready    = in_w && sel_q && s_axi_wready;

    m0_awready    = in_idle && grant[0];
    m1_awready    = in_idle && grant[1];
    s_axi_awvalid = resetn && (state_q == StAw);

    m0_bvalid    = in_b && !sel_q && s_axi_bvalid;
    m1_bvalid    = in_b && sel_q && s_axi_bvalid;
    m0_bresp     = (in_b && !sel_q) ? s_axi_bresp : 2'b00;
    m1_bresp     = (in_b && sel_q) ? s_axi_bresp : 2'b00;
    s_axi_bready = in_b && (sel_q ? m1_bready : m0_bready);

    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;

    case (state_q)
      StIdle: begin
        if (|grant) begin
          sel_d     = grant[1];
          awid_d    = grant[1] ? ID_WIDTH'(M1_ID) : ID_WIDTH'(M0_ID);
          awaddr_d  = grant[1] ? m1_awaddr : m0_awaddr;
          awlen_d   = grant[1] ? m1_awlen : m0_awlen;
          awsize_d  = grant[1] ? m1_awsize : m0_awsize;
          awburst_d = grant[1] ? m1_awburst : m0_awburst;
          state_d   = StAw;
        end
      end
      StAw: begin
        if (s_axi_awready) begin
          cnt_d   = 8'd0;
          state_d = StW;
        end
      end
      StW: begin
        if (s_axi_wvalid && s_axi_wready) begin
          if (mst_wlast != s_axi_wlast) err_d = 1'b1;
          // Counter stops on the final beat, so awlen 255 never wraps early.
          if (s_axi_wlast) state_d = StB;
          else             cnt_d   = cnt_q + 8'd1;
        end
      end
      StB: begin
        if (s_axi_bvalid && s_axi_bready) begin
          last_d  = sel_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;  // m0 wins the first tie
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= 8'd0;
      awsize_q  <= 3'd0;
      awburst_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
    end
  end

endmodule

// File: doc/mem_axi_wr_2x1_arb.md
MEM_AXI_WR_2X1_ARB -- requirements
Module: mem_axi_wr_2x1_arb

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH 32 (address bits); DATA_WIDTH 32 (data bits); STRB_WIDTH DATA_WIDTH/8 (strobe bits); ID_WIDTH 4 (AXI ID bits).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- mN_aw{addr,len,size,burst,valid}  in  ADDR_WIDTH/8/3/2/1  master N write address, N = 0 (dcache writeback) and 1 (uncached store).
- mN_awready  out  1  master N AW accepted.
- mN_w{data,strb,last,valid}  in  DATA_WIDTH/STRB_WIDTH/1/1  master N write data.
- mN_wready  out  1  master N W accepted.
- mN_bvalid  out  1  master N response valid.
- mN_bresp  out  2  master N response code.
- mN_bready  in  1  master N response ready.
- s_axi_aw{id,addr,len,size,burst,valid}  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  memory write address.
- s_axi_awready  in  1.
- s_axi_aw{lock,cache,prot}  out  1/4/3  tied 0.
- s_axi_w{data,strb,last,valid}  out  DATA_WIDTH/STRB_WIDTH/1/1.
- s_axi_wready  in  1.
- s_axi_b{id,resp,valid}  in  ID_WIDTH/2/1.
- s_axi_bready  out  1.
- wlast_err  out  1  sticky: master wlast disagreed with the beat count.

Function
REQ-003 The block SHALL be an FSM with states IDLE, AW, W, B; exactly one write transaction is in flight at a time.
REQ-004 In IDLE with any mN_awvalid, the grant SHALL go to the requester; if both are valid, to the master not granted last (round-robin pointer).
REQ-005 In IDLE, mN_awready SHALL equal the granted mN_awvalid combinationally.
REQ-006 On that handshake the block SHALL register the master's AW fields plus awid (0 for m0, 1 for m1) and go to AW.
REQ-007 In AW, s_axi_awvalid SHALL be 1 with the registered fields; on s_axi_awready, go to W.
REQ-008 s_axi_awvalid SHALL be 1 only in AW.
REQ-009 In W, the granted master's wdata/wstrb/wvalid SHALL pass to s_axi_w*, and s_axi_wready SHALL pass to its mN_wready.
REQ-010 In W, the non-granted wready SHALL be 0; outside W, s_axi_wvalid and all mN_wready SHALL be 0.
REQ-011 An 8-bit beat counter SHALL clear on entry to W and increment per W handshake.
REQ-012 s_axi_wlast SHALL be (counter == registered awlen), independent of master wlast.
REQ-013 On the handshake with counter == awlen, the FSM SHALL go to B.
REQ-014 wlast_err SHALL set on any W handshake where the master's wlast differs from the computed wlast, and hold until reset.
REQ-015 In B, s_axi_bvalid and s_axi_bresp SHALL route to the granted master only; s_axi_bready = granted mN_bready.
REQ-016 On the B handshake, the FSM SHALL go to IDLE and set the round-robin pointer to the granted master.
REQ-017 s_axi_bid SHALL NOT be checked; a mismatch is ignored.
REQ-018 A new grant SHALL be possible the cycle after returning to IDLE, so the minimum turnaround is 1 IDLE cycle.
REQ-019 awlen = 0 SHALL give a single beat with s_axi_wlast = 1.
REQ-020 awlen = 255 SHALL give 256 beats with no counter overflow before the last beat.
REQ-021 mN_awvalid deasserted while not granted SHALL have no effect; the pointer SHALL change only on B completion.

Reset
REQ-022 With resetn = 0 at a clk edge: state IDLE, pointer set so m0 wins a tie, beat counter 0, wlast_err 0, registered AW fields 0.
REQ-023 While in reset, all valid/ready outputs SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon it without completing W or B; the masters and memory are reset together.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the master ID constants (M0_ID = 0, M1_ID = 1), and the AXI tie-off constants for lock, cache and prot.
REQ-026 The round-robin grant logic SHALL be one sub-module, rr_arb2, with inputs req[1:0] and last_grant and output grant[1:0].

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Only m0 awvalid, awaddr 0x100, awlen 3 -> s_axi_awid 0, four W beats, s_axi_wlast on beat 4 only, m0_bvalid on B, m1 sees nothing.
- m0 and m1 awvalid in the same cycle after reset -> m0 served first, m1 granted in the IDLE cycle after m0's B handshake.
- Both requesting continuously for 4 transactions, awlen 0 -> grants alternate m0, m1, m0, m1.
- m1 awlen 1 with m1_wlast asserted on beat 1 -> wlast_err = 1 and remains 1, transaction still ends after 2 beats.
- s_axi_awready held low 5 cycles then s_axi_wready toggling -> no W beat before the AW handshake, beat count exact.
- resetn low during W beat 2 of awlen 7 -> next cycle all valid/ready outputs 0, state IDLE, next request accepted normally.
